// File: rtl/des_key_schedule.sv
// des_key_schedule
// Sequential DES key scheduler feeding the PC-2 compression stage.
// A key_load pulse captures the 64-bit key, applies PC-1 and then walks
// the C/D halves through the 16 round rotations. Each round value is
// presented on cd_out with a valid/ack handshake. Encrypt order uses left
// rotations; decrypt order starts from C0D0 (K16) and rotates right.
//
// round_num shows the current round modulo 16 on four bits, so round 16
// reads as 0 while round_valid is still high.
//
// Optional build macro: DES_KEY_PARITY_CHECK_EN
//   defined   - each key byte is checked for odd parity on key_load and
//               parity_err is raised (sticky until next load or rst).
//   undefined - parity_err is tied low and no checking logic exists.
module des_key_schedule #(
    parameter bit AUTO_ADVANCE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [0:63] key_in,
    input  logic        decrypt,
    input  logic        round_ack,
    output logic [0:55] cd_out,
    output logic [3:0]  round_num,
    output logic        round_valid,
    output logic        schedule_done,
    output logic        busy,
    output logic        parity_err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_t;

    // Permuted choice 1: drops the parity bits and splits the key into C||D.
    function automatic logic [0:55] pc1(input logic [0:63] k);
        return {k[56], k[48], k[40], k[32], k[24], k[16], k[8],  k[0],
                k[57], k[49], k[41], k[33], k[25], k[17], k[9],  k[1],
                k[58], k[50], k[42], k[34], k[26], k[18], k[10], k[2],
                k[59], k[51], k[43], k[35],
                k[62], k[54], k[46], k[38], k[30], k[22], k[14], k[6],
                k[61], k[53], k[45], k[37], k[29], k[21], k[13], k[5],
                k[60], k[52], k[44], k[36], k[28], k[20], k[12], k[4],
                k[27], k[19], k[11], k[3]};
    endfunction

    // Per-round rotation amount for rounds 1..16.
    function automatic logic [1:0] shift_amt(input logic [4:0] idx);
        logic [1:0] amt;
        case (idx)
            5'd1, 5'd2, 5'd9, 5'd16: amt = 2'd1;
            default:                 amt = 2'd2;
        endcase
        return amt;
    endfunction

    // 28-bit rotate of one half; bit 0 is the MSB, so a left rotate moves
    // bit 0 to the tail.
    function automatic logic [0:27] rot28(input logic [0:27] x,
                                          input logic [1:0]  n,
                                          input logic        right);
        logic [0:27] y;
        if (right) begin
            case (n)
                2'd1:    y = {x[27], x[0:26]};
                2'd2:    y = {x[26:27], x[0:25]};
                default: y = x;
            endcase
        end else begin
            case (n)
                2'd1:    y = {x[1:27], x[0]};
                2'd2:    y = {x[2:27], x[0:1]};
                default: y = x;
            endcase
        end
        return y;
    endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
    // Returns 1 when any key byte has even parity.
    function automatic logic key_parity_bad(input logic [0:63] k);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (~^k[8*i +: 8]) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction
`endif

    state_t      state_r;
    state_t      state_s;
    logic [0:55] cd_r;
    logic [0:55] cd_s;
    logic [3:0]  round_r;
    logic [3:0]  round_s;
    logic        dec_r;
    logic        dec_s;
    logic        done_r;
    logic        done_s;
    logic        advance_s;
    logic [0:55] pc1_s;
    logic [0:55] load_cd_s;
    logic [4:0]  step_idx_s;
    logic [1:0]  step_amt_s;
    logic [0:55] step_cd_s;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic        perr_r;
    logic        perr_s;
`else
    logic        parity_bits_unused_s;
    assign parity_bits_unused_s = ^{key_in[7],  key_in[15], key_in[23], key_in[31],
                                    key_in[39], key_in[47], key_in[55], key_in[63]};
`endif

    assign advance_s = AUTO_ADVANCE ? 1'b1 : round_ack;

    // First-round value on load: K1 = C1D1 for encrypt, K16 = C0D0 for decrypt.
    always_comb begin
        pc1_s = pc1(key_in);
        if (decrypt) begin
            load_cd_s = pc1_s;
        end else begin
            load_cd_s = {rot28(pc1_s[0:27], 2'd1, 1'b0),
                         rot28(pc1_s[28:55], 2'd1, 1'b0)};
        end
    end

    // Next-round value: encrypt uses S[r+1] leftwards, decrypt S[17-r] rightwards.
    always_comb begin
        if (dec_r) begin
            step_idx_s = 5'd17 - {1'b0, round_r};
        end else begin
            step_idx_s = {1'b0, round_r} + 5'd1;
        end
        step_amt_s = shift_amt(step_idx_s);
        step_cd_s  = {rot28(cd_r[0:27],  step_amt_s, dec_r),
                      rot28(cd_r[28:55], step_amt_s, dec_r)};
    end

    // Next-state and next-register logic; a load overrides any advance.
    always_comb begin
        state_s = state_r;
        cd_s    = cd_r;
        round_s = round_r;
        dec_s   = dec_r;
        done_s  = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
        perr_s  = perr_r;
`endif
        if (key_load) begin
            state_s = ROUND;
            cd_s    = load_cd_s;
            round_s = 4'd1;
            dec_s   = decrypt;
`ifdef DES_KEY_PARITY_CHECK_EN
            perr_s  = key_parity_bad(key_in);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                ROUND: begin
                    if (advance_s) begin
                        // round_r == 0 encodes round 16
                        if (round_r == 4'd0) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            cd_s    = step_cd_s;
                            round_s = round_r + 4'd1;
                        end
                    end else begin
                        state_s = ROUND;
                    end
                end
                default: begin
                    state_s = IDLE;
                    round_s = 4'd0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cd_r    <= 56'd0;
            round_r <= 4'd0;
            dec_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cd_r    <= cd_s;
            round_r <= (state_s == IDLE) ? 4'd0 : round_s;
            dec_r   <= dec_s;
            done_r  <= done_s;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    // Sticky parity flag, refreshed on every key load.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_r <= 1'b0;
        end else begin
            perr_r <= perr_s;
        end
    end

    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

    assign cd_out        = cd_r;
    assign round_num     = round_r;
    assign round_valid   = (state_r == ROUND);
    assign busy          = (state_r == ROUND);
    assign schedule_done = done_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Testbench for des_key_schedule: one instance advancing on round_ack and
// one with AUTO_ADVANCE=1, both checked every cycle against a closed-form
// model (cumulative rotation from C0D0), plus literal round values.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [0:63] key_in;
    logic        decrypt;
    logic        round_ack;

    logic [0:55] cd0, cd1;
    logic [3:0]  rn0, rn1;
    logic        valid0, valid1, done0, done1, busy0, busy1, perr0, perr1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    localparam logic [0:63] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [0:63] KEY_BAD = 64'h133457799BBCDFF0;
    localparam logic [0:63] KEY_ODD = 64'h0101010101010101;
    localparam logic [0:63] KEY_B   = 64'h0E329232EA6D0D73;

    localparam int PC1 [56] = '{56,48,40,32,24,16,8,0,57,49,41,33,25,17,9,1,
                                58,50,42,34,26,18,10,2,59,51,43,35,62,54,46,38,
                                30,22,14,6,61,53,45,37,29,21,13,5,60,52,44,36,
                                28,20,12,4,27,19,11,3};
    localparam int SHIFTS [17] = '{0,1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct {
        bit          act;
        bit          done;
        bit          zero;
        bit          perr;
        bit          dec;
        int          r;
        logic [0:63] key;
    } model_t;

    model_t m0, m1;

    always #5 clk = ~clk;

    des_key_schedule #(.AUTO_ADVANCE(1'b0)) dut_ack (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .decrypt(decrypt), .round_ack(round_ack), .cd_out(cd0),
        .round_num(rn0), .round_valid(valid0), .schedule_done(done0),
        .busy(busy0), .parity_err(perr0)
    );

    des_key_schedule #(.AUTO_ADVANCE(1'b1)) dut_auto (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .decrypt(decrypt), .round_ack(1'b0), .cd_out(cd1),
        .round_num(rn1), .round_valid(valid1), .schedule_done(done1),
        .busy(busy1), .parity_err(perr1)
    );

    // Round key r: encrypt is C0D0 rotated left by S[1]+..+S[r];
    // decrypt round r is the encrypt key of round 17-r.
    function automatic logic [0:55] model_cd(input logic [0:63] k, input bit dec, input int r);
        logic [0:55] p;
        logic [0:55] res;
        int kidx;
        int sh;
        for (int i = 0; i < 56; i++) p[i] = k[PC1[i]];
        kidx = dec ? 17 - r : r;
        sh = 0;
        for (int j = 1; j <= kidx; j++) sh += SHIFTS[j];
        sh = sh % 28;
        for (int i = 0; i < 28; i++) begin
            res[i]      = p[(i + sh) % 28];
            res[28 + i] = p[28 + ((i + sh) % 28)];
        end
        return res;
    endfunction

    function automatic bit key_bad(input logic [0:63] k);
        bit bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            int cnt = 0;
            for (int t = 0; t < 8; t++) cnt += int'(k[8*b + t]);
            if (cnt % 2 == 0) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic bit exp_perr(input logic [0:63] k);
`ifdef DES_KEY_PARITY_CHECK_EN
        return key_bad(k);
`else
        return 1'b0;
`endif
    endfunction

    function automatic model_t model_step(input model_t s, input bit r, input bit kl,
                                          input logic [0:63] k, input bit dec, input bit adv);
        model_t n = s;
        n.done = 1'b0;
        if (r) begin
            n.act = 1'b0; n.zero = 1'b1; n.perr = 1'b0; n.r = 0;
        end else if (kl) begin
            n.act = 1'b1; n.zero = 1'b0; n.r = 1; n.key = k; n.dec = dec;
            n.perr = exp_perr(k);
        end else if (s.act && adv) begin
            if (s.r == 16) begin
                n.act = 1'b0; n.done = 1'b1;
            end else begin
                n.r = s.r + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input model_t s, input logic [0:55] cd,
                              input logic [3:0] rn, input logic v, input logic d,
                              input logic b, input logic pe);
        logic [0:55] ecd;
        ecd = s.zero ? 56'd0 : model_cd(s.key, s.dec, s.r);
        chk({tag, ".cd_out"}, {8'd0, cd}, {8'd0, ecd});
        chk({tag, ".round_num"}, {60'd0, rn}, s.act ? 64'(s.r % 16) : 64'd0);
        chk({tag, ".round_valid"}, {63'd0, v}, {63'd0, s.act});
        chk({tag, ".busy"}, {63'd0, b}, {63'd0, s.act});
        chk({tag, ".schedule_done"}, {63'd0, d}, {63'd0, s.done});
        chk({tag, ".parity_err"}, {63'd0, pe}, {63'd0, s.perr});
    endtask

    // Model advances on the same edge as the DUTs.
    always @(posedge clk) begin
        m0 <= model_step(m0, rst, key_load, key_in, decrypt, round_ack);
        m1 <= model_step(m1, rst, key_load, key_in, decrypt, 1'b1);
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_inst("ack", m0, cd0, rn0, valid0, done0, busy0, perr0);
            check_inst("auto", m1, cd1, rn1, valid1, done1, busy1, perr1);
        end
    end

    task automatic tick(input bit r, input bit kl, input logic [0:63] k,
                        input bit dec, input bit ack);
        rst = r; key_load = kl; key_in = k; decrypt = dec; round_ack = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; key_load = 1'b0; key_in = 64'd0; decrypt = 1'b0; round_ack = 1'b0;
        tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("reset.cd_out", {8'd0, cd0}, 64'd0);
        chk("reset.round_num", {60'd0, rn0}, 64'd0);
        chk("reset.valid", {63'd0, valid0}, 64'd0);

        // ack while idle is ignored
        tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("idle_ack.valid", {63'd0, valid0}, 64'd0);

        // encrypt run
        tick(1'b0, 1'b1, KEY_A, 1'b0, 1'b0);
        chk("enc.r1", {8'd0, cd0}, 64'h00E19955FAACCF1E);
        chk("enc.r1.num", {60'd0, rn0}, 64'd1);
        tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        chk("enc.r2", {8'd0, cd0}, 64'h00C332ABF5599E3D);
        chk("enc.r2.num", {60'd0, rn0}, 64'd2);
        tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        repeat (5) begin
            tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b0);
            chk("hold.num", {60'd0, rn0}, 64'd3);
        end
        repeat (13) tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        chk("enc.r16", {8'd0, cd0}, 64'h00F0CCAAF556678F);
        chk("enc.r16.num", {60'd0, rn0}, 64'd0);
        chk("enc.r16.valid", {63'd0, valid0}, 64'd1);
        tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        chk("enc.done", {63'd0, done0}, 64'd1);
        chk("enc.done.valid", {63'd0, valid0}, 64'd0);
        chk("enc.done.cd_hold", {8'd0, cd0}, 64'h00F0CCAAF556678F);
        tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b0);
        chk("enc.done_pulse", {63'd0, done0}, 64'd0);

        // decrypt run
        tick(1'b0, 1'b1, KEY_A, 1'b1, 1'b0);
        chk("dec.r1", {8'd0, cd0}, 64'h00F0CCAAF556678F);
        tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        chk("dec.r2", {8'd0, cd0}, 64'h00F866557AAB33C7);
        repeat (14) tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        chk("dec.r16", {8'd0, cd0}, 64'h00E19955FAACCF1E);
        tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        chk("dec.done", {63'd0, done0}, 64'd1);
        tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b0);

        // reload with ack at round 7, then reset at round 9
        tick(1'b0, 1'b1, KEY_A, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b0, KEY_A, 1'b0, 1'b1);
        chk("restart.pre.num", {60'd0, rn0}, 64'd7);
        tick(1'b0, 1'b1, KEY_B, 1'b1, 1'b1);
        chk("restart.num", {60'd0, rn0}, 64'd1);
        chk("restart.no_done", {63'd0, done0}, 64'd0);
        repeat (8) tick(1'b0, 1'b0, KEY_B, 1'b0, 1'b1);
        chk("mid.num", {60'd0, rn0}, 64'd9);
        tick(1'b1, 1'b0, KEY_B, 1'b0, 1'b1);
        chk("midrst.cd", {8'd0, cd0}, 64'd0);
        chk("midrst.num", {60'd0, rn0}, 64'd0);
        chk("midrst.valid", {63'd0, valid0}, 64'd0);
        chk("midrst.done", {63'd0, done0}, 64'd0);

        // parity
        tick(1'b0, 1'b1, KEY_BAD, 1'b0, 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("parity.bad", {63'd0, perr0}, 64'd1);
`else
        chk("parity.bad", {63'd0, perr0}, 64'd0);
`endif
        repeat (3) tick(1'b0, 1'b0, KEY_BAD, 1'b0, 1'b1);
        tick(1'b0, 1'b1, KEY_ODD, 1'b0, 1'b0);
        chk("parity.ok", {63'd0, perr0}, 64'd0);

        // random handshake traffic checked by the model
        repeat (80) begin
            tick(1'b0, $urandom_range(0, 24) == 0, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
